// File: rtl/wishbone_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wishbone_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT = 32;
  localparam int unsigned DATA_WIDTH_DEFAULT = 32;

  // Encoding doubles as the one-hot grant vector (bit n = master n).
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StGnt0 = 2'b01,
    StGnt1 = 2'b10
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wishbone_arbiter_mux.sv
// Combinational routing between the two masters and the shared bus, selected by the
// one-hot grant. With no grant every bus output and every return path is held at 0.
module wishbone_arbiter_mux
  import wishbone_pkg::*;
#(
  parameter int unsigned AddrWidth = ADDR_WIDTH_DEFAULT,
  parameter int unsigned DataWidth = DATA_WIDTH_DEFAULT
) (
  input  logic [1:0]           grant_i,
  input  logic [AddrWidth-1:0] m0_adr_i,
  input  logic [DataWidth-1:0] m0_dat_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [AddrWidth-1:0] m1_adr_i,
  input  logic [DataWidth-1:0] m1_dat_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  output logic                 m0_ack_o,
  output logic [DataWidth-1:0] m0_dat_o,
  output logic                 m1_ack_o,
  output logic [DataWidth-1:0] m1_dat_o,
  output logic [AddrWidth-1:0] bus_adr_o,
  output logic [DataWidth-1:0] bus_dat_o,
  output logic                 bus_cyc_o,
  output logic                 bus_stb_o,
  output logic                 bus_we_o,
  input  logic                 bus_ack_i,
  input  logic [DataWidth-1:0] bus_dat_i
);

  logic sel_m0;
  logic sel_m1;

  assign sel_m0 = (grant_i == GRANT_M0);
  assign sel_m1 = (grant_i == GRANT_M1);

  // Forward the granted master's request onto the shared bus.
  always_comb begin
    bus_adr_o = '0;
    bus_dat_o = '0;
    bus_cyc_o = 1'b0;
    bus_stb_o = 1'b0;
    bus_we_o  = 1'b0;
    if (sel_m0) begin
      bus_adr_o = m0_adr_i;
      bus_dat_o = m0_dat_i;
      bus_cyc_o = m0_cyc_i;
      bus_stb_o = m0_stb_i;
      bus_we_o  = m0_we_i;
    end else if (sel_m1) begin
      bus_adr_o = m1_adr_i;
      bus_dat_o = m1_dat_i;
      bus_cyc_o = m1_cyc_i;
      bus_stb_o = m1_stb_i;
      bus_we_o  = m1_we_i;
    end
  end

  // Return ack/data to the granted master only; ack is gated by its own cyc & stb so a
  // stale target ack (arriving while stb is low) is swallowed.
  always_comb begin
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;
    if (sel_m0) begin
      m0_ack_o = bus_ack_i & m0_cyc_i & m0_stb_i;
      m0_dat_o = bus_dat_i;
    end else if (sel_m1) begin
      m1_ack_o = bus_ack_i & m1_cyc_i & m1_stb_i;
      m1_dat_o = bus_dat_i;
    end
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Two-master to one-target Wishbone arbiter. Grant is registered and held for a whole
// tenure (while the granted master keeps cyc high); the data path is combinational.
// Build option: define WB_ARB_ROUND_ROBIN_EN for round-robin contention resolution,
// otherwise master 0 has fixed priority.
module wishbone_arbiter
  import wishbone_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] adr_o_m0,
  input  logic [DATA_WIDTH-1:0] dat_o_m0,
  input  logic                  cyc_o_m0,
  input  logic                  stb_o_m0,
  input  logic                  we_o_m0,
  input  logic [ADDR_WIDTH-1:0] adr_o_m1,
  input  logic [DATA_WIDTH-1:0] dat_o_m1,
  input  logic                  cyc_o_m1,
  input  logic                  stb_o_m1,
  input  logic                  we_o_m1,
  output logic                  ack_i_m0,
  output logic [DATA_WIDTH-1:0] dat_i_m0,
  output logic                  ack_i_m1,
  output logic [DATA_WIDTH-1:0] dat_i_m1,
  output logic [ADDR_WIDTH-1:0] adr_o_out,
  output logic [DATA_WIDTH-1:0] dat_o_out,
  output logic                  cyc_o_out,
  output logic                  stb_o_out,
  output logic                  we_o_out,
  input  logic                  ack_i_in,
  input  logic [DATA_WIDTH-1:0] dat_i_in,
  output logic [1:0]            grant_o
);

  arb_state_t state_q;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // 0 = master 0 held the last grant, 1 = master 1. Reset to 1 so master 0 wins first.
  logic last_grant_q;

  // Track the most recent grant holder; only consulted from idle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_grant_q <= 1'b1;
    end else if (state_q == StGnt0) begin
      last_grant_q <= 1'b0;
    end else if (state_q == StGnt1) begin
      last_grant_q <= 1'b1;
    end
  end
`endif

  // Arbitration FSM: pick a master from idle, hold during cyc, hand off on release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cyc_o_m0 && cyc_o_m1) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
            state_q <= last_grant_q ? StGnt0 : StGnt1;
`else
            state_q <= StGnt0;
`endif
          end else if (cyc_o_m0) begin
            state_q <= StGnt0;
          end else if (cyc_o_m1) begin
            state_q <= StGnt1;
          end
        end
        StGnt0: begin
          // Hand straight to a waiting master 1 so there is no idle bubble.
          if (!cyc_o_m0) begin
            state_q <= cyc_o_m1 ? StGnt1 : StIdle;
          end
        end
        StGnt1: begin
          if (!cyc_o_m1) begin
            state_q <= cyc_o_m0 ? StGnt0 : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // State encoding is the one-hot grant, so grant_o is a registered output.
  assign grant_o = state_q;

  wishbone_arbiter_mux #(
    .AddrWidth(ADDR_WIDTH),
    .DataWidth(DATA_WIDTH)
  ) u_mux (
    .grant_i  (state_q),
    .m0_adr_i (adr_o_m0),
    .m0_dat_i (dat_o_m0),
    .m0_cyc_i (cyc_o_m0),
    .m0_stb_i (stb_o_m0),
    .m0_we_i  (we_o_m0),
    .m1_adr_i (adr_o_m1),
    .m1_dat_i (dat_o_m1),
    .m1_cyc_i (cyc_o_m1),
    .m1_stb_i (stb_o_m1),
    .m1_we_i  (we_o_m1),
    .m0_ack_o (ack_i_m0),
    .m0_dat_o (dat_i_m0),
    .m1_ack_o (ack_i_m1),
    .m1_dat_o (dat_i_m1),
    .bus_adr_o(adr_o_out),
    .bus_dat_o(dat_o_out),
    .bus_cyc_o(cyc_o_out),
    .bus_stb_o(stb_o_out),
    .bus_we_o (we_o_out),
    .bus_ack_i(ack_i_in),
    .bus_dat_i(dat_i_in)
  );

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter: reset, single master, contention, tenure hold,
// stale ack and asynchronous reset mid-transfer.
module tb_wishbone_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [AW-1:0] adr_o_m0, adr_o_m1;
  logic [DW-1:0] dat_o_m0, dat_o_m1;
  logic          cyc_o_m0, cyc_o_m1, stb_o_m0, stb_o_m1, we_o_m0, we_o_m1;
  logic          ack_i_m0, ack_i_m1;
  logic [DW-1:0] dat_i_m0, dat_i_m1;
  logic [AW-1:0] adr_o_out;
  logic [DW-1:0] dat_o_out;
  logic          cyc_o_out, stb_o_out, we_o_out;
  logic          ack_i_in;
  logic [DW-1:0] dat_i_in;
  logic [1:0]    grant_o;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  wishbone_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .adr_o_m0 (adr_o_m0),
    .dat_o_m0 (dat_o_m0),
    .cyc_o_m0 (cyc_o_m0),
    .stb_o_m0 (stb_o_m0),
    .we_o_m0  (we_o_m0),
    .adr_o_m1 (adr_o_m1),
    .dat_o_m1 (dat_o_m1),
    .cyc_o_m1 (cyc_o_m1),
    .stb_o_m1 (stb_o_m1),
    .we_o_m1  (we_o_m1),
    .ack_i_m0 (ack_i_m0),
    .dat_i_m0 (dat_i_m0),
    .ack_i_m1 (ack_i_m1),
    .dat_i_m1 (dat_i_m1),
    .adr_o_out(adr_o_out),
    .dat_o_out(dat_o_out),
    .cyc_o_out(cyc_o_out),
    .stb_o_out(stb_o_out),
    .we_o_out (we_o_out),
    .ack_i_in (ack_i_in),
    .dat_i_in (dat_i_in),
    .grant_o  (grant_o)
  );

  // Inputs change 1 ns after the rising edge; checks follow later in the same cycle.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    adr_o_m0 = '0; dat_o_m0 = '0; cyc_o_m0 = 0; stb_o_m0 = 0; we_o_m0 = 0;
    adr_o_m1 = '0; dat_o_m1 = '0; cyc_o_m1 = 0; stb_o_m1 = 0; we_o_m1 = 0;
    ack_i_in = 0; dat_i_in = '0;
  endtask

  task automatic do_reset();
    rst_n_i = 0;
    clear_inputs();
    step();
    rst_n_i = 1;
    step();
  endtask

  task automatic test_reset();
    rst_n_i = 0;
    clear_inputs();
    cyc_o_m0 = 1; stb_o_m0 = 1; adr_o_m0 = 32'h44; ack_i_in = 1; dat_i_in = 32'h1234;
    step(); step();
    n_checks++;
    if (grant_o !== 2'b00) begin
      n_fail++; $display("FAIL reset_grant: got %b want 00", grant_o);
    end
    n_checks++;
    if ({cyc_o_out, stb_o_out, we_o_out, ack_i_m0, ack_i_m1} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {cyc_o_out, stb_o_out, we_o_out, ack_i_m0, ack_i_m1});
    end
    n_checks++;
    if (adr_o_out !== 32'h0 || dat_i_m0 !== 32'h0 || dat_i_m1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got adr=%h d0=%h d1=%h want 0", adr_o_out, dat_i_m0, dat_i_m1);
    end
    ack_i_in = 0;
    rst_n_i = 1;
    #1;
    n_checks++;
    if (grant_o !== 2'b00) begin
      n_fail++; $display("FAIL reset_release_grant: got %b want 00", grant_o);
    end
    step();
    n_checks++;
    if (grant_o !== 2'b01) begin
      n_fail++; $display("FAIL reset_first_grant: got %b want 01", grant_o);
    end
    n_checks++;
    if (cyc_o_out !== 1'b1 || adr_o_out !== 32'h44) begin
      n_fail++; $display("FAIL reset_route: got cyc=%b adr=%h want 1 00000044", cyc_o_out, adr_o_out);
    end
  endtask

  task automatic test_single_master();
    do_reset();
    cyc_o_m1 = 1; stb_o_m1 = 1; we_o_m1 = 0; adr_o_m1 = 32'h10;
    step();
    n_checks++;
    if (grant_o !== 2'b10 || adr_o_out !== 32'h10 || we_o_out !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: got g=%b adr=%h we=%b want 10 00000010 0",
               grant_o, adr_o_out, we_o_out);
    end
    step(); step();
    ack_i_in = 1; dat_i_in = 32'hCAFE0001;
    #1;
    n_checks++;
    if (ack_i_m1 !== 1'b1 || dat_i_m1 !== 32'hCAFE0001) begin
      n_fail++;
      $display("FAIL single_ack_m1: got ack=%b dat=%h want 1 cafe0001", ack_i_m1, dat_i_m1);
    end
    n_checks++;
    if (ack_i_m0 !== 1'b0 || dat_i_m0 !== 32'h0) begin
      n_fail++; $display("FAIL single_m0_quiet: got ack=%b dat=%h want 0 0", ack_i_m0, dat_i_m0);
    end
    step();
    ack_i_in = 0; cyc_o_m1 = 0; stb_o_m1 = 0;
    step();
    n_checks++;
    if (grant_o !== 2'b00) begin
      n_fail++; $display("FAIL single_idle: got %b want 00", grant_o);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    do_reset();
    cyc_o_m0 = 1; stb_o_m0 = 1; adr_o_m0 = 32'h20;
    cyc_o_m1 = 1; stb_o_m1 = 1; adr_o_m1 = 32'h30;
    step();
    n_checks++;
    if (grant_o !== 2'b01 || adr_o_out !== 32'h20) begin
      n_fail++; $display("FAIL contend_first: got g=%b adr=%h want 01 00000020", grant_o, adr_o_out);
    end
    cyc_o_m0 = 0; stb_o_m0 = 0;
    #1;
    n_checks++;
    if (grant_o !== 2'b01 || cyc_o_out !== 1'b0) begin
      n_fail++; $display("FAIL contend_release: got g=%b cyc=%b want 01 0", grant_o, cyc_o_out);
    end
    step();
    n_checks++;
    if (grant_o !== 2'b10 || adr_o_out !== 32'h30) begin
      n_fail++; $display("FAIL contend_handoff: got g=%b adr=%h want 10 00000030", grant_o, adr_o_out);
    end
    cyc_o_m1 = 0; stb_o_m1 = 0;
    step();
    // A lone master 0 tenure makes master 0 the most recent grant holder.
    cyc_o_m0 = 1;
    step();
    cyc_o_m0 = 0;
    step();
    n_checks++;
    if (grant_o !== 2'b00) begin
      n_fail++; $display("FAIL contend_idle: got %b want 00", grant_o);
    end
    cyc_o_m0 = 1; cyc_o_m1 = 1;
    step();
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_g = 2'b10;
`else
    exp_g = 2'b01;
`endif
    n_checks++;
    if (grant_o !== exp_g) begin
      n_fail++; $display("FAIL contend_second: got %b want %b", grant_o, exp_g);
    end
    cyc_o_m0 = 0; cyc_o_m1 = 0;
    step();
    n_checks++;
    if (grant_o !== 2'b00) begin
      n_fail++; $display("FAIL contend_done: got %b want 00", grant_o);
    end
  endtask

  task automatic test_tenure_hold();
    do_reset();
    cyc_o_m0 = 1; stb_o_m0 = 1; we_o_m0 = 1; adr_o_m0 = 32'h0; dat_o_m0 = 32'hA000_0000;
    step();
    cyc_o_m1 = 1; stb_o_m1 = 1; adr_o_m1 = 32'h80;
    for (int k = 0; k < 4; k++) begin
      adr_o_m0 = 32'(4 * k);
      dat_o_m0 = 32'hA000_0000 + 32'(k);
      ack_i_in = 1;
      #1;
      n_checks++;
      if (grant_o !== 2'b01 || ack_i_m0 !== 1'b1 || ack_i_m1 !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_beat%0d: got g=%b a0=%b a1=%b want 01 1 0",
                 k, grant_o, ack_i_m0, ack_i_m1);
      end
      n_checks++;
      if (adr_o_out !== 32'(4 * k) || dat_o_out !== 32'hA000_0000 + 32'(k) || we_o_out !== 1'b1)
      begin
        n_fail++;
        $display("FAIL hold_route%0d: got adr=%h dat=%h we=%b want %h %h 1",
                 k, adr_o_out, dat_o_out, we_o_out, 32'(4 * k), 32'hA000_0000 + 32'(k));
      end
      step();
    end
    ack_i_in = 0; cyc_o_m0 = 0; stb_o_m0 = 0; we_o_m0 = 0;
    #1;
    n_checks++;
    if (grant_o !== 2'b01) begin
      n_fail++; $display("FAIL hold_last: got %b want 01", grant_o);
    end
    step();
    n_checks++;
    if (grant_o !== 2'b10 || adr_o_out !== 32'h80) begin
      n_fail++; $display("FAIL hold_handoff: got g=%b adr=%h want 10 00000080", grant_o, adr_o_out);
    end
    cyc_o_m1 = 0; stb_o_m1 = 0;
    step();
  endtask

  task automatic test_stale_ack();
    do_reset();
    cyc_o_m0 = 1; stb_o_m0 = 0;
    step();
    ack_i_in = 1; dat_i_in = 32'h5555_AAAA;
    #1;
    n_checks++;
    if (grant_o !== 2'b01 || ack_i_m0 !== 1'b0 || ack_i_m1 !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_ack: got g=%b a0=%b a1=%b want 01 0 0", grant_o, ack_i_m0, ack_i_m1);
    end
    ack_i_in = 0; cyc_o_m0 = 0;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc_o_m1 = 1; stb_o_m1 = 1; adr_o_m1 = 32'h90;
    step();
    n_checks++;
    if (grant_o !== 2'b10 || cyc_o_out !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: got g=%b cyc=%b want 10 1", grant_o, cyc_o_out);
    end
    ack_i_in = 1;
    #2;
    rst_n_i = 0;
    #1;
    n_checks++;
    if (cyc_o_out !== 1'b0 || stb_o_out !== 1'b0 || grant_o !== 2'b00) begin
      n_fail++;
      $display("FAIL areset_drop: got cyc=%b stb=%b g=%b want 0 0 00", cyc_o_out, stb_o_out, grant_o);
    end
    n_checks++;
    if (ack_i_m1 !== 1'b0 || ack_i_m0 !== 1'b0 || adr_o_out !== 32'h0) begin
      n_fail++;
      $display("FAIL areset_ack: got a0=%b a1=%b adr=%h want 0 0 0", ack_i_m0, ack_i_m1, adr_o_out);
    end
    clear_inputs();
    step();
    rst_n_i = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_contention();
    test_tenure_hold();
    test_stale_ack();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wishbone_arbiter.md
Name: wishbone_arbiter

Overview:
- Two-master to one-target Wishbone arbiter.
- Sits upstream of the address-split interconnect. Lets two masters (e.g. a CPU and a DMA) share its single master port.
- Grant is held for a whole bus tenure, meaning while the granted master keeps cyc asserted.
- Arbitration is registered; the data path is combinational while a master is granted.

Parameters:
- ADDR_WIDTH, 32, width of address buses.
- DATA_WIDTH, 32, width of data buses.

Ports:
- clk_i  input  1  bus clock
- rst_n_i  input  1  reset, asynchronous, active-low
- adr_o_m0 / adr_o_m1  input  ADDR_WIDTH  master 0/1 address
- dat_o_m0 / dat_o_m1  input  DATA_WIDTH  master 0/1 write data
- cyc_o_m0 / cyc_o_m1  input  1  master 0/1 cycle (bus request)
- stb_o_m0 / stb_o_m1  input  1  master 0/1 strobe
- we_o_m0 / we_o_m1  input  1  master 0/1 write enable
- ack_i_m0 / ack_i_m1  output  1  acknowledge to master 0/1
- dat_i_m0 / dat_i_m1  output  DATA_WIDTH  read data to master 0/1
- adr_o_out  output  ADDR_WIDTH  shared-bus address
- dat_o_out  output  DATA_WIDTH  shared-bus write data
- cyc_o_out  output  1  shared-bus cycle
- stb_o_out  output  1  shared-bus strobe
- we_o_out  output  1  shared-bus write enable
- ack_i_in  input  1  shared-bus acknowledge
- dat_i_in  input  DATA_WIDTH  shared-bus read data
- grant_o  output  2  one-hot current grant; 00 = idle

Behaviour:
- Clock and reset: single clock clk_i; rst_n_i is asynchronous, active-low.
- States: IDLE, GNT0, GNT1. State register and last_grant register are reset asynchronously to IDLE / master 1, so master 0 wins the first round-robin contest.
- Outputs during reset and in IDLE:
  - all *_out signals are 0;
  - ack_i_m0/m1 = 0, dat_i_m0/m1 = 0, grant_o = 00.
- IDLE transitions:
  - only cyc_o_m0 → GNT0; only cyc_o_m1 → GNT1;
  - both → the master not equal to last_grant;
  - neither → stay in IDLE.
- Latency: the grant becomes visible the cycle after the request. A master therefore sees at least one wait cycle from IDLE.
- GNTn routing:
  - *_out = master n inputs, combinationally.
  - ack_i_mn = ack_i_in & cyc_o_mn & stb_o_mn; dat_i_mn = dat_i_in.
  - The non-granted master gets ack 0 and dat_i 0.
  - grant_o = one-hot n.
  - last_grant <= n on entry.
- Release: a GNTn → next state transition is decided when cyc_o_mn = 0.
  - Other master requesting → go directly to GNT(other), with no IDLE bubble.
  - Otherwise → IDLE.
  - In the release cycle, cyc_o_out follows cyc_o_mn, i.e. 0.
- Hold: while cyc_o_mn = 1 the grant never changes, regardless of the other master's requests. This preserves Wishbone block/RMW atomicity.
- Stale-ack guard: if ack_i_in arrives while the granted master has stb = 0, no master sees it.
- Simultaneous events: a release and a new request from the same master in the same cycle count as release. Round robin then applies if the other master is waiting.
- Reset mid-transfer: all bus outputs drop asynchronously; in-flight transfers are abandoned with no ack.
- Flow control: no buffering and no pipelining; one outstanding transfer per tenure, following classic Wishbone.

Optional Feature:
- Macro: WB_ARB_ROUND_ROBIN_EN.
- Defined: contention is resolved round-robin via last_grant, as described above.
- Undefined: fixed priority, master 0 always wins contention. The last_grant register is not synthesized. Release from GNT1 with both masters requesting goes to GNT0.

Decomposition:
- Shared package wishbone_pkg holds:
  - state encoding typedef arb_state_t (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10);
  - GRANT_NONE/GRANT_M0/GRANT_M1 constants;
  - default ADDR/DATA width constants.
- One natural sub-module, wishbone_arbiter_mux: purely combinational routing of master signals to the bus and the ack/data return, selected by grant.
- The FSM stays in the top module.

Test Plan:
- Reset: hold rst_n_i=0 with cyc_o_m0=1 → all outputs 0, grant_o=00. Release reset → GNT0 one cycle later, grant_o=01.
- Single master: m1 read of adr 0x10, target acks after 2 cycles with dat 0xCAFE0001 → ack_i_m1=1, dat_i_m1=0xCAFE0001; m0 sees ack 0.
- Contention: cyc_o_m0 and cyc_o_m1 both rise in the same cycle from reset → GNT0 first. When m0 drops cyc → GNT1 the next cycle with no IDLE cycle. In the next contest from IDLE, m1 wins (round-robin build) or m0 wins (macro undefined).
- Tenure hold: m0 performs a 4-beat block write (adr 0x0..0xC) while m1 requests throughout → grant stays 01 for all 4 acks; m1 granted only after cyc_o_m0 falls.
- Stale ack: pulse ack_i_in=1 while granted master has stb=0 → ack_i_m0=ack_i_m1=0.
- Async reset mid-transfer: assert rst_n_i between clock edges during a GNT1 transfer → cyc_o_out/stb_o_out drop immediately, grant_o=00, no ack is passed.
